// File: rtl/edge_event_arbiter_pkg.sv
// rtl/edge_event_arbiter_pkg.sv - shared state encoding and default sizes for the edge event arbiter
package edge_event_arbiter_pkg;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_PRESENT = 1'b1
    } state_t;

    localparam int NCHAN_DEF = 4;
    localparam int IDXW_DEF  = 2;

endpackage

// File: rtl/edge_event_arbiter_rr_pick.sv
// rtl/edge_event_arbiter_rr_pick.sv - combinational round-robin priority encoder
module rr_pick
    import edge_event_arbiter_pkg::*;
#(
    parameter int NCHAN = NCHAN_DEF,
    parameter int IDXW  = IDXW_DEF
) (
    input  logic [NCHAN-1:0] req,
    input  logic [IDXW-1:0]  last,
    output logic             any,
    output logic [IDXW-1:0]  idx
);

    // Walk offsets from farthest to nearest so the channel right after
    // 'last' (wrapping modulo NCHAN) is the final, winning assignment.
    always_comb begin
        int c;
        c   = 0;
        any = 1'b0;
        idx = '0;
        for (int k = NCHAN; k >= 1; k--) begin
            c = (int'(last) + k) % NCHAN;
            if (req[c]) begin
                any = 1'b1;
                idx = IDXW'(c);
            end
        end
    end

endmodule

// File: rtl/edge_event_arbiter.sv
// rtl/edge_event_arbiter.sv - buffers per-channel edge pulses and arbitrates them onto one valid/ready port
module edge_event_arbiter
    import edge_event_arbiter_pkg::*;
#(
    parameter int NCHAN = NCHAN_DEF,
    parameter int IDXW  = IDXW_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [NCHAN-1:0] pos_pulse,
    input  logic [NCHAN-1:0] neg_pulse,
    output logic             evt_valid,
    input  logic             evt_ready,
    output logic [IDXW-1:0]  evt_chan,
    output logic             evt_rising,
    output logic [NCHAN-1:0] overflow,
    input  logic             overflow_clr
);

    state_t           state_q, state_d;
    logic [NCHAN-1:0] pend_q, pend_d;
    logic [NCHAN-1:0] ptype_q, ptype_d;
    logic [NCHAN-1:0] ovf_q, ovf_d;
    logic [NCHAN-1:0] grant_vec;
    logic [NCHAN-1:0] pulse;
    logic [NCHAN-1:0] ovf_set;
    logic [IDXW-1:0]  last_q, last_d;
    logic [IDXW-1:0]  chan_q, chan_d;
    logic             rising_q, rising_d;
    logic             grant;
    logic             pick_any;
    logic [IDXW-1:0]  pick_idx;

    rr_pick #(
        .NCHAN (NCHAN),
        .IDXW  (IDXW)
    ) u_pick (
        .req  (pend_q),
        .last (last_q),
        .any  (pick_any),
        .idx  (pick_idx)
    );

    always_comb begin
        state_d  = state_q;
        grant    = 1'b0;
        chan_d   = chan_q;
        rising_d = rising_q;
        last_d   = last_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_any) begin
                    grant    = 1'b1;
                    chan_d   = pick_idx;
                    rising_d = ptype_q[pick_idx];
                    state_d  = ST_PRESENT;
                end
            end
            ST_PRESENT: begin
                if (evt_ready) begin
                    last_d  = chan_q;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // A pulse landing in the same cycle its channel is granted is a fresh
    // event, not a loss: the grant already consumed the previous one.
    always_comb begin
        grant_vec = '0;
        for (int i = 0; i < NCHAN; i++) begin
            grant_vec[i] = grant && (pick_idx == IDXW'(i));
        end
        pulse   = pos_pulse | neg_pulse;
        pend_d  = pulse | (pend_q & ~grant_vec);
        ptype_d = (pulse & pos_pulse) | (~pulse & ptype_q);
        ovf_set = (pos_pulse & neg_pulse) | (pulse & pend_q & ~grant_vec);
        ovf_d   = ovf_set | (ovf_q & ~{NCHAN{overflow_clr}});
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            pend_q   <= '0;
            ptype_q  <= '0;
            ovf_q    <= '0;
            last_q   <= IDXW'(NCHAN - 1);
            chan_q   <= '0;
            rising_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pend_q   <= pend_d;
            ptype_q  <= ptype_d;
            ovf_q    <= ovf_d;
            last_q   <= last_d;
            chan_q   <= chan_d;
            rising_q <= rising_d;
        end
    end

    assign evt_valid  = (state_q == ST_PRESENT);
    assign evt_chan   = chan_q;
    assign evt_rising = rising_q;
    assign overflow   = ovf_q;

endmodule

// File: tb/tb_edge_event_arbiter.sv
// tb/tb_edge_event_arbiter.sv - randomized and directed bench for edge_event_arbiter against a reference model
module tb_edge_event_arbiter;

    localparam int N = 4;
    localparam int W = 2;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [N-1:0] pos_pulse;
    logic [N-1:0] neg_pulse;
    logic         evt_valid;
    logic         evt_ready;
    logic [W-1:0] evt_chan;
    logic         evt_rising;
    logic [N-1:0] overflow;
    logic         overflow_clr;

    int errors = 0;
    int checks = 0;

    int m_pend[N];
    int m_ptype[N];
    int m_ovf[N];
    int m_valid, m_chan, m_rising, m_last;
    int log_q[$];

    edge_event_arbiter #(.NCHAN(N), .IDXW(W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .pos_pulse    (pos_pulse),
        .neg_pulse    (neg_pulse),
        .evt_valid    (evt_valid),
        .evt_ready    (evt_ready),
        .evt_chan     (evt_chan),
        .evt_rising   (evt_rising),
        .overflow     (overflow),
        .overflow_clr (overflow_clr)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_pend[i] = 0; m_ptype[i] = 0; m_ovf[i] = 0;
        end
        m_valid = 0; m_chan = 0; m_rising = 0; m_last = N - 1;
    endtask

    function automatic int rr_ref();
        for (int k = 1; k <= N; k++) begin
            if (m_pend[(m_last + k) % N] != 0) return (m_last + k) % N;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] model_ovf();
        logic [N-1:0] v;
        for (int i = 0; i < N; i++) v[i] = (m_ovf[i] != 0);
        return v;
    endfunction

    task automatic model_step(input logic [N-1:0] p, input logic [N-1:0] n, input logic r, input logic c);
        int g;
        int newov;
        g = -1;
        if (m_valid != 0) begin
            if (r) begin
                m_last  = m_chan;
                m_valid = 0;
            end
        end else begin
            g = rr_ref();
        end
        if (g >= 0) begin
            m_valid  = 1;
            m_chan   = g;
            m_rising = m_ptype[g];
        end
        for (int i = 0; i < N; i++) begin
            newov = 0;
            if (p[i] || n[i]) begin
                if (p[i] && n[i]) newov = 1;
                else if (m_pend[i] != 0 && g != i) newov = 1;
                m_pend[i]  = 1;
                m_ptype[i] = p[i];
            end else if (g == i) begin
                m_pend[i] = 0;
            end
            if (newov != 0) m_ovf[i] = 1;
            else if (c) m_ovf[i] = 0;
        end
    endtask

    task automatic compare_model(input string tag);
        check_eq({tag, "_valid"}, evt_valid, m_valid);
        if (m_valid != 0) begin
            check_eq({tag, "_chan"}, evt_chan, m_chan);
            check_eq({tag, "_rising"}, evt_rising, m_rising);
        end
        check_eq({tag, "_ovf"}, overflow, model_ovf());
    endtask

    task automatic cyc(input string tag, input logic [N-1:0] p, input logic [N-1:0] n, input logic r, input logic c);
        pos_pulse    = p;
        neg_pulse    = n;
        evt_ready    = r;
        overflow_clr = c;
        @(negedge clk);
        compare_model(tag);
        if (evt_valid && evt_ready) log_q.push_back(int'(evt_chan) + 16 * int'(evt_rising));
        model_step(p, n, r, c);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        pos_pulse = '0; neg_pulse = '0; evt_ready = 1'b0; overflow_clr = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        log_q.delete();
    endtask

    initial begin
        rst_n = 1'b0;
        pos_pulse = '0; neg_pulse = '0; evt_ready = 1'b0; overflow_clr = 1'b0;
        model_reset();
        #1;
        check_eq("rst_valid", evt_valid, 0);
        check_eq("rst_chan", evt_chan, 0);
        check_eq("rst_rising", evt_rising, 0);
        check_eq("rst_ovf", overflow, 0);
        do_reset();

        // single event latency
        cyc("t2a", 4'b0100, 4'b0000, 1'b1, 1'b0);
        check_eq("t2_lat_early", evt_valid, 0);
        cyc("t2b", 4'b0000, 4'b0000, 1'b1, 1'b0);
        check_eq("t2_lat_valid", evt_valid, 1);
        check_eq("t2_chan", evt_chan, 2);
        check_eq("t2_rising", evt_rising, 1);
        for (int i = 0; i < 5; i++) cyc("t2c", 4'b0000, 4'b0000, 1'b1, 1'b0);
        check_eq("t2_count", log_q.size(), 1);

        // round-robin order
        do_reset();
        cyc("t3a", 4'b1011, 4'b0000, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) cyc("t3b", 4'b0000, 4'b0000, 1'b1, 1'b0);
        check_eq("t3_count", log_q.size(), 3);
        if (log_q.size() == 3) begin
            check_eq("t3_first", log_q[0], 16 + 0);
            check_eq("t3_second", log_q[1], 16 + 1);
            check_eq("t3_third", log_q[2], 16 + 3);
        end
        log_q.delete();
        cyc("t3c", 4'b0000, 4'b1001, 1'b1, 1'b0);
        for (int i = 0; i < 6; i++) cyc("t3d", 4'b0000, 4'b0000, 1'b1, 1'b0);
        check_eq("t3_count2", log_q.size(), 2);
        if (log_q.size() == 2) begin
            check_eq("t3_wrap_first", log_q[0], 0);
            check_eq("t3_wrap_second", log_q[1], 3);
        end

        // backpressure
        do_reset();
        cyc("t4a", 4'b0000, 4'b0010, 1'b0, 1'b0);
        cyc("t4b", 4'b0000, 4'b0000, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            cyc("t4c", 4'b0000, 4'b0000, 1'b0, 1'b0);
            check_eq("t4_hold_valid", evt_valid, 1);
            check_eq("t4_hold_chan", evt_chan, 1);
            check_eq("t4_hold_rising", evt_rising, 0);
        end
        cyc("t4d", 4'b0000, 4'b0000, 1'b1, 1'b0);
        check_eq("t4_accept", log_q.size(), 1);
        check_eq("t4_after_valid", evt_valid, 0);

        // overflow and sticky clear
        do_reset();
        cyc("t5a", 4'b0001, 4'b0000, 1'b0, 1'b0);
        cyc("t5b", 4'b0000, 4'b0000, 1'b0, 1'b0);
        cyc("t5c", 4'b0000, 4'b0010, 1'b0, 1'b0);
        cyc("t5d", 4'b0010, 4'b0000, 1'b0, 1'b0);
        cyc("t5e", 4'b0000, 4'b0000, 1'b0, 1'b0);
        check_eq("t5_ovf1", overflow[1], 1);
        for (int i = 0; i < 6; i++) cyc("t5f", 4'b0000, 4'b0000, 1'b1, 1'b0);
        check_eq("t5_count", log_q.size(), 2);
        if (log_q.size() == 2) check_eq("t5_ch1_rising", log_q[1], 16 + 1);
        cyc("t5g", 4'b0010, 4'b0010, 1'b1, 1'b1);
        check_eq("t5_clr_collide", overflow[1], 1);
        cyc("t5h", 4'b0000, 4'b0000, 1'b1, 1'b1);
        check_eq("t5_clr", overflow, 0);
        for (int i = 0; i < 4; i++) cyc("t5i", 4'b0000, 4'b0000, 1'b1, 1'b0);

        // pulse in the cycle its channel is granted
        do_reset();
        cyc("t6a", 4'b0001, 4'b0000, 1'b1, 1'b0);
        cyc("t6b", 4'b0001, 4'b0000, 1'b1, 1'b0);
        for (int i = 0; i < 6; i++) cyc("t6c", 4'b0000, 4'b0000, 1'b1, 1'b0);
        check_eq("t6_count", log_q.size(), 2);
        check_eq("t6_ovf0", overflow[0], 0);

        // async reset while presenting
        do_reset();
        cyc("t1a", 4'b0100, 4'b1000, 1'b0, 1'b0);
        cyc("t1b", 4'b1000, 4'b1000, 1'b0, 1'b0);
        check_eq("t1_pre_valid", evt_valid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("t1_async_valid", evt_valid, 0);
        check_eq("t1_async_ovf", overflow, 0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        log_q.delete();
        for (int i = 0; i < 5; i++) cyc("t1c", 4'b0000, 4'b0000, 1'b1, 1'b0);
        check_eq("t1_no_event", log_q.size(), 0);

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            logic [N-1:0] rp, rn;
            rp = N'($urandom & $urandom & $urandom);
            rn = N'($urandom & $urandom & $urandom);
            cyc("rnd", rp, rn, ($urandom_range(0, 3) != 0), ($urandom_range(0, 15) == 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
